mux4_scan_ctrl: RTL
===================

// Module: mux4_scan_ctrl
// PURPOSE
//   Upstream sequencer for the 4:1 mux blocks (cond/if/case variants).
//   On a start pulse it steps the 2-bit select through channels 0..3 and
//   holds each channel for DWELL cycles. At the end of each dwell it
//   captures the mux output into a 4-bit snapshot, then reports completion
//   with a done pulse and a valid level.
// PARAMETERS
//   DWELL  4  cycles each channel is held on sel; legal range 1..2**CNT_W
//   CNT_W  3  width of the dwell counter
// PORTS
//   clk      in   1  single clock; all state changes on rising edge
//   rst_n    in   1  reset, asynchronous, active-low
//   start    in   1  scan request; sampled in IDLE only
//   mux_out  in   1  output of the downstream 4:1 mux
//   sel      out  2  select driven to the mux; registered
//   busy     out  1  high while in SCAN
//   done     out  1  one-cycle pulse in DONE state
//   sample   out  4  sample[i] = mux_out captured while sel==i
//   valid    out  1  sample holds a complete scan; level
// BEHAVIOUR
//   Reset (rst_n=0, async):
//   - state=IDLE, sel=0, cnt=0, busy=0, done=0, sample=4'b0000, valid=0.
//   - Takes effect immediately, including mid-scan; no partial result kept.
//   FSM states: IDLE -> SCAN -> DONE -> IDLE.
//   IDLE:
//   - sel=0, busy=0.
//   - If start=1 at an edge: go to SCAN with sel=0, cnt=0, and clear valid.
//   - sample keeps its old value until overwritten channel by channel.
//   SCAN:
//   - busy=1.
//   - Each edge: if cnt!=DWELL-1 then cnt++.
//   - Otherwise: sample[sel] <= mux_out and cnt <= 0.
//     - If sel==3, go to DONE.
//     - Else sel <= sel+1.
//   DONE:
//   - done=1 and busy=0 for exactly one cycle.
//   - valid <= 1; next state IDLE; sel <= 0.
//   Timing: start sampled at edge E0.
//   - Channel i is captured at edge E0+(i+1)*DWELL.
//   - done is high in the cycle after edge E0+4*DWELL.
//   - Total start-to-done latency is 4*DWELL+1 cycles.
//   start handling:
//   - start in SCAN or DONE is ignored; it is not queued.
//   - start held high re-triggers from IDLE, so a new scan begins the
//     cycle after DONE.
//   DWELL=1: capture every cycle; sel steps on every edge 0,1,2,3.
//   sel wraps only through DONE (3 -> 0); it never takes X or skips a value.
//   mux_out is treated as settled by the capture edge; no extra sync stage.
// TESTING
//   1. Reset: assert rst_n=0 -> sel=0, busy=0, done=0, sample=0, valid=0.
//   2. Basic scan: DWELL=4, mux data in[3:0]=4'b1010, 1-cycle start.
//      -> sel holds 0,1,2,3 for 4 cycles each; busy high for 16 cycles;
//         done pulses once 17 cycles after the start edge;
//         sample=4'b1010; valid=1.
//   3. DWELL=1, in=4'b0110.
//      -> sel changes every cycle; done 5 cycles after start;
//         sample=4'b0110.
//   4. Extra start pulses during SCAN (cycles 3 and 9).
//      -> no restart; single done at cycle 17; sample still correct.
//   5. rst_n pulsed low at cycle 7 of a scan.
//      -> all outputs reset immediately; no done;
//         a fresh start yields a full correct scan.
//   6. start held high, mux data changed to 4'b0101 after first done.
//      -> back-to-back scans: valid drops 1 cycle after first done,
//         second done yields sample=4'b0101.

Source files
------------

// File: rtl/mux4_scan_ctrl.sv
// rtl/mux4_scan_ctrl.sv - select sequencer and snapshot capture for a 4:1 mux
//
// Purpose:
//   A start pulse begins a scan. The block steps sel through channels 0..3
//   and holds each channel for DWELL cycles. On the last cycle of each dwell
//   it captures mux_out into sample[sel]. After channel 3 it pulses done for
//   one cycle, then raises valid.
//
// Parameters:
//   DWELL   cycles each channel is held on sel (1..2**CNT_W)
//   CNT_W   width of the dwell counter
//
// Ports:
//   clk      in   1  clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   start    in   1  scan request, only sampled while idle
//   mux_out  in   1  output of the downstream 4:1 mux
//   sel      out  2  registered select driven to the mux
//   busy     out  1  high while scanning
//   done     out  1  one-cycle completion pulse
//   sample   out  4  sample[i] = mux_out captured while sel == i
//   valid    out  1  sample holds a complete scan (level)
module mux4_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int CNT_W = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mux_out,
  output logic [1:0] sel,
  output logic       busy,
  output logic       done,
  output logic [3:0] sample,
  output logic       valid
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Terminal count of one dwell; with DWELL=1 this is 0, so every scan
  // cycle is a capture cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       sel_q;
  logic             busy_q;
  logic             done_q;
  logic [3:0]       sample_q;
  logic             valid_q;

  // busy and done are registered alongside the state transition so they
  // line up exactly with the SCAN and DONE states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sel_q    <= 2'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sample_q <= 4'b0000;
      valid_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          sel_q <= 2'd0;
          cnt_q <= '0;
          if (start) begin
            state_q <= ST_SCAN;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            sample_q[sel_q] <= mux_out;
            cnt_q           <= '0;
            if (sel_q == 2'd3) begin
              // sel stays at 3 through DONE and returns to 0 on exit
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              sel_q <= sel_q + 2'd1;
            end
          end
        end
        ST_DONE: begin
          valid_q <= 1'b1;
          sel_q   <= 2'd0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          sel_q   <= 2'd0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sel    = sel_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign sample = sample_q;
  assign valid  = valid_q;

endmodule
